// File: rtl/cnn_pkg.sv
// Shared definitions for the result reporting path.
// - ASCII constants for the bytes of the text report.
// - rr_state_t: FSM states of result_reporter.
// - rr_phase_t: which part of the message is being sent.
// - msg_len(): number of bytes in one report for a given configuration.
package cnn_pkg;

   localparam logic [7:0] ZERO    = 8'h30;
   localparam logic [7:0] SPACE   = 8'h20;
   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] LF      = 8'h0A;
   localparam logic [7:0] QMARK   = 8'h3F;
   localparam logic [7:0] A_UPPER = 8'h41;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_ACCEPT,
      WAIT_IDLE,
      FINISH
   } rr_state_t;

   typedef enum logic [1:0] {
      PH_DIGIT,
      PH_LOGITS,
      PH_CR,
      PH_LF
   } rr_phase_t;

   // Digit, optionally one space plus DATA_WIDTH/4 hex digits per class, then CR LF.
   function automatic int msg_len(input int num_classes, input int data_width,
                                  input int send_logits);
      if (send_logits != 0)
         return 1 + num_classes * (1 + data_width / 4) + 2;
      else
         return 3;
   endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit converter.
// Ports:
//   nibble  in  4  value 0..15
//   ascii   out 8  '0'..'9' or 'A'..'F'
module nibble_to_ascii
   import cnn_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10)
         ascii = ZERO + {4'b0000, nibble};
      else
         ascii = A_UPPER + {4'b0000, nibble} - 8'd10;
   end

endmodule

// File: rtl/result_reporter.sv
// Turns a prediction (index + logits) into a framed text line for uart_tx:
//   "<digit>[ <hex logit>]xNUM_CLASSES\r\n", one byte per tx_dv/tx_busy handshake.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, idx, logits  capture request and the data to report
//   tx_dv, tx_byte    byte strobe and byte to uart_tx
//   tx_busy           uart_tx busy flag
//   busy              report in progress
//   done              one-cycle pulse after the LF has left the transmitter
//   dropped           one-cycle pulse when a start is ignored
module result_reporter
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_CLASSES    = 10,
   parameter int IDXW           = 4,
   parameter int SEND_LOGITS    = 1,
   parameter int ACCEPT_TIMEOUT = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [IDXW-1:0]                   idx,
   input  logic [NUM_CLASSES*DATA_WIDTH-1:0] logits,
   output logic                              tx_dv,
   output logic [7:0]                        tx_byte,
   input  logic                              tx_busy,
   output logic                              busy,
   output logic                              done,
   output logic                              dropped
);

   localparam int HEXD = DATA_WIDTH / 4;
   localparam int KW   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam int PW   = $clog2(HEXD + 1);
   localparam int TW   = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_CLASSES - 1);
   localparam logic [PW-1:0] P_LAST = PW'(HEXD);
   localparam logic [TW-1:0] T_LAST = TW'(ACCEPT_TIMEOUT - 1);

   rr_state_t                         state_reg, state_next;
   rr_phase_t                         phase_reg;
   logic [KW-1:0]                     k_reg;
   logic [PW-1:0]                     p_reg;
   logic [TW-1:0]                     to_reg;
   logic [IDXW-1:0]                   idx_reg;
   logic [NUM_CLASSES*DATA_WIDTH-1:0] logits_reg;
   logic [7:0]                        tx_byte_reg;

   logic [DATA_WIDTH-1:0] logit_arr [NUM_CLASSES];
   logic [DATA_WIDTH-1:0] cur_logit;
   logic [PW-1:0]         nib_pos;
   logic [3:0]            cur_nibble;
   logic [7:0]            nib_ascii;
   logic [7:0]            byte_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_split
         assign logit_arr[gi] = logits_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // p=1 selects the most significant nibble, p=HEXD the least significant.
   assign cur_logit  = logit_arr[k_reg];
   assign nib_pos    = P_LAST - p_reg;
   assign cur_nibble = 4'(cur_logit >> {nib_pos, 2'b00});

   nibble_to_ascii u_nib (
      .nibble (cur_nibble),
      .ascii  (nib_ascii)
   );

   always_comb begin
      byte_sel = 8'h00;
      case (phase_reg)
         PH_DIGIT:  byte_sel = (32'(idx_reg) < 32'(NUM_CLASSES)) ? ZERO + 8'(idx_reg) : QMARK;
         PH_LOGITS: byte_sel = (p_reg == '0) ? SPACE : nib_ascii;
         PH_CR:     byte_sel = CR;
         PH_LF:     byte_sel = LF;
         default:   byte_sel = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      tx_dv      = 1'b0;
      done       = 1'b0;
      busy       = (state_reg != IDLE) && (state_reg != FINISH);
      dropped    = start && (state_reg != IDLE);
      case (state_reg)
         IDLE:        if (start) state_next = LOAD;
         LOAD:        state_next = SEND;
         SEND: begin
            if (!tx_busy) begin
               tx_dv      = 1'b1;
               state_next = WAIT_ACCEPT;
            end
         end
         // A transmitter that never raises busy must not stall the report forever.
         WAIT_ACCEPT: if (tx_busy || to_reg == T_LAST) state_next = WAIT_IDLE;
         WAIT_IDLE:   if (!tx_busy) state_next = (phase_reg == PH_LF) ? FINISH : LOAD;
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default:     state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_reg   <= PH_DIGIT;
         k_reg       <= '0;
         p_reg       <= '0;
         to_reg      <= '0;
         idx_reg     <= '0;
         logits_reg  <= '0;
         tx_byte_reg <= 8'h00;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  idx_reg    <= idx;
                  logits_reg <= logits;
                  phase_reg  <= PH_DIGIT;
                  k_reg      <= '0;
                  p_reg      <= '0;
               end
            end
            LOAD: begin
               tx_byte_reg <= byte_sel;
               to_reg      <= '0;
            end
            WAIT_ACCEPT: if (!tx_busy) to_reg <= to_reg + 1'b1;
            WAIT_IDLE: begin
               if (!tx_busy) begin
                  case (phase_reg)
                     PH_DIGIT: begin
                        phase_reg <= (SEND_LOGITS != 0) ? PH_LOGITS : PH_CR;
                        k_reg     <= '0;
                        p_reg     <= '0;
                     end
                     PH_LOGITS: begin
                        if (p_reg == P_LAST) begin
                           p_reg <= '0;
                           if (k_reg == K_LAST) begin
                              k_reg     <= '0;
                              phase_reg <= PH_CR;
                           end else begin
                              k_reg <= k_reg + 1'b1;
                           end
                        end else begin
                           p_reg <= p_reg + 1'b1;
                        end
                     end
                     PH_CR:   phase_reg <= PH_LF;
                     default: phase_reg <= PH_DIGIT;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_byte = tx_byte_reg;

endmodule

// File: tb/tb_result_reporter.sv
// Bench for result_reporter: two instances (with and without logits), a simple
// uart_tx busy model, a byte monitor, and a string-based reference of the report.
module tb_result_reporter;

   typedef logic [7:0] bq_t [$];

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start1 = 1'b0, start0 = 1'b0;
   logic [3:0]   idx1 = '0, idx0 = '0;
   logic [159:0] logits1 = '0, logits0 = '0;
   logic         tx_dv1, tx_dv0, busy1, busy0, done1, done0, dropped1, dropped0;
   logic [7:0]   tx_byte1, tx_byte0;
   logic         tx_busy1 = 1'b0, tx_busy0 = 1'b0;

   int   busy_len = 20;
   bit   dead = 1'b0;
   int   cnt1 = 0, cnt0 = 0;
   int   cyc = 0;
   logic [7:0] rx1[$], rx0[$];
   int   dv_cyc1[$];
   int   done1_cnt = 0, done0_cnt = 0, drop1_cnt = 0, viol_cnt = 0;
   int   n_checks = 0, n_pass = 0;

   always #5 clk = ~clk;

   result_reporter #(.DATA_WIDTH(16), .NUM_CLASSES(10), .IDXW(4), .SEND_LOGITS(1),
                     .ACCEPT_TIMEOUT(4)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .idx(idx1), .logits(logits1),
      .tx_dv(tx_dv1), .tx_byte(tx_byte1), .tx_busy(tx_busy1),
      .busy(busy1), .done(done1), .dropped(dropped1));

   result_reporter #(.DATA_WIDTH(16), .NUM_CLASSES(10), .IDXW(4), .SEND_LOGITS(0),
                     .ACCEPT_TIMEOUT(4)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .idx(idx0), .logits(logits0),
      .tx_dv(tx_dv0), .tx_byte(tx_byte0), .tx_busy(tx_busy0),
      .busy(busy0), .done(done0), .dropped(dropped0));

   // uart_tx stand-in: busy for busy_len cycles after each accepted byte, or never when dead.
   always @(posedge clk) begin
      if (dead) begin
         tx_busy1 <= 1'b0;
         tx_busy0 <= 1'b0;
      end else begin
         if (tx_busy1) begin
            if (cnt1 <= 1) tx_busy1 <= 1'b0;
            cnt1 <= cnt1 - 1;
         end else if (tx_dv1) begin
            tx_busy1 <= 1'b1;
            cnt1     <= busy_len;
         end
         if (tx_busy0) begin
            if (cnt0 <= 1) tx_busy0 <= 1'b0;
            cnt0 <= cnt0 - 1;
         end else if (tx_dv0) begin
            tx_busy0 <= 1'b1;
            cnt0     <= busy_len;
         end
      end
   end

   // Monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (tx_dv1) begin
         rx1.push_back(tx_byte1);
         dv_cyc1.push_back(cyc);
         if (tx_busy1) viol_cnt <= viol_cnt + 1;
      end
      if (tx_dv0) begin
         rx0.push_back(tx_byte0);
         if (tx_busy0) viol_cnt <= viol_cnt + 1;
      end
      if (done1)    done1_cnt <= done1_cnt + 1;
      if (done0)    done0_cnt <= done0_cnt + 1;
      if (dropped1) drop1_cnt <= drop1_cnt + 1;
   end

   // Reference: the report as text, hex digits forced to uppercase.
   function automatic bq_t ref_msg(input logic [3:0] i, input logic [159:0] lg,
                                   input bit with_logits);
      bq_t        r;
      string      s;
      logic [15:0] v;
      logic [7:0] b;
      s = (i < 4'd10) ? $sformatf("%0d", i) : "?";
      if (with_logits)
         for (int k = 0; k < 10; k++) begin
            v = lg[k*16 +: 16];
            s = {s, $sformatf(" %h", v)};
         end
      for (int c = 0; c < s.len(); c++) begin
         b = s[c];
         if (b >= "a" && b <= "f") b = b - 8'd32;
         r.push_back(b);
      end
      r.push_back(8'h0D);
      r.push_back(8'h0A);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [159:0] rand_logits();
      logic [159:0] lg;
      for (int k = 0; k < 10; k++) lg[k*16 +: 16] = 16'($urandom);
      return lg;
   endfunction

   task automatic pulse_start1(input logic [3:0] i, input logic [159:0] lg);
      idx1 = i; logits1 = lg; start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      idx1 = 4'($urandom); logits1 = rand_logits();
   endtask

   task automatic wait_done1(input string tag);
      int n = 0;
      while (done1 !== 1'b1 && n < 5000) begin
         tick(1);
         n++;
      end
      check({tag, " done reached"}, 32'(done1), 32'd1);
   endtask

   task automatic check_msg1(input int base, input bq_t exp, input string tag);
      check({tag, " length"}, 32'(rx1.size() - base), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         if (base + i < rx1.size())
            check($sformatf("%s byte%0d", tag, i), 32'(rx1[base+i]), 32'(exp[i]));
   endtask

   task automatic full_report1(input logic [3:0] i, input logic [159:0] lg, input string tag);
      int base, d0;
      bq_t exp;
      base = rx1.size(); d0 = done1_cnt;
      exp = ref_msg(i, lg, 1'b1);
      pulse_start1(i, lg);
      check({tag, " busy after start"}, 32'(busy1), 32'd1);
      wait_done1(tag);
      check({tag, " busy in done cycle"}, 32'(busy1), 32'd0);
      tick(3);
      check_msg1(base, exp, tag);
      check({tag, " done count"}, 32'(done1_cnt - d0), 32'd1);
   endtask

   initial begin
      logic [159:0] lg;
      bq_t exp;
      int base, d0, dr0, n, min_gap;

      // Reset state
      tick(3);
      check("rst tx_dv", 32'(tx_dv1), 32'd0);
      check("rst tx_byte", 32'(tx_byte1), 32'd0);
      check("rst busy", 32'(busy1), 32'd0);
      check("rst done", 32'(done1), 32'd0);
      check("rst dropped", 32'(dropped1), 32'd0);
      check("rst busy0", 32'(busy0), 32'd0);
      reset = 1'b0;
      tick(2);

      // 1: idx 7, one non-zero logit, 20-cycle busy per byte
      lg = '0; lg[7*16 +: 16] = 16'h0180;
      full_report1(4'd7, lg, "t1");
      check("t1 byte count 53", 32'(rx1.size()), 32'd53);

      // 2: negative logit shown as raw uppercase hex
      busy_len = 3;
      lg = rand_logits(); lg[15:0] = 16'hFF80;
      base = rx1.size();
      full_report1(4'd0, lg, "t2");
      check("t2 space", 32'(rx1[base+1]), 32'h20);
      check("t2 F", 32'(rx1[base+2]), 32'h46);

      // Random reports, including out-of-range indices
      for (int r = 0; r < 3; r++) begin
         busy_len = $urandom_range(1, 6);
         full_report1(4'($urandom_range(0, 15)), rand_logits(), $sformatf("rnd%0d", r));
      end
      full_report1(4'd10, rand_logits(), "idx10");

      // 4: starts during a report and in its FINISH cycle are dropped
      busy_len = 4;
      lg = rand_logits();
      base = rx1.size(); d0 = done1_cnt; dr0 = drop1_cnt;
      exp = ref_msg(4'd2, lg, 1'b1);
      pulse_start1(4'd2, lg);
      n = 0;
      while (rx1.size() - base < 10 && n < 2000) begin tick(1); n++; end
      check("t4 reached byte 10", 32'(rx1.size() - base >= 10), 32'd1);
      pulse_start1(4'd9, rand_logits());
      wait_done1("t4");
      idx1 = 4'd5; start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      tick(200);
      check_msg1(base, exp, "t4");
      check("t4 done count", 32'(done1_cnt - d0), 32'd1);
      check("t4 dropped count", 32'(drop1_cnt - dr0), 32'd2);
      check("t4 idle after", 32'(busy1), 32'd0);

      // 5: dead transmitter, each byte released by the accept timeout
      dead = 1'b1;
      tick(30);
      base = rx1.size();
      lg = rand_logits();
      full_report1(4'd3, lg, "t5");
      min_gap = 1000;
      for (int i = base + 1; i < dv_cyc1.size(); i++)
         if (dv_cyc1[i] - dv_cyc1[i-1] < min_gap) min_gap = dv_cyc1[i] - dv_cyc1[i-1];
      check("t5 timeout waited", 32'(min_gap >= 5), 32'd1);
      dead = 1'b0;
      busy_len = 5;

      // 6: reset mid-report abandons it; next report is complete
      base = rx1.size(); d0 = done1_cnt;
      pulse_start1(4'd6, rand_logits());
      n = 0;
      while (rx1.size() - base < 20 && n < 2000) begin tick(1); n++; end
      check("t6 reached byte 20", 32'(rx1.size() - base >= 20), 32'd1);
      reset = 1'b1;
      tick(1);
      check("t6 tx_dv in reset", 32'(tx_dv1), 32'd0);
      check("t6 busy in reset", 32'(busy1), 32'd0);
      reset = 1'b0;
      tick(100);
      check("t6 no done", 32'(done1_cnt - d0), 32'd0);
      full_report1(4'd1, rand_logits(), "t6new");

      // 3: digit + CRLF variant, out-of-range index
      busy_len = 6;
      base = rx0.size(); d0 = done0_cnt;
      idx0 = 4'd12; logits0 = rand_logits(); start0 = 1'b1;
      tick(1);
      start0 = 1'b0; idx0 = 4'd1;
      n = 0;
      while (done0 !== 1'b1 && n < 500) begin tick(1); n++; end
      check("t3 done reached", 32'(done0), 32'd1);
      check("t3 tx_busy low at done", 32'(tx_busy0), 32'd0);
      tick(3);
      check("t3 length", 32'(rx0.size() - base), 32'd3);
      exp = ref_msg(4'd12, '0, 1'b0);
      for (int i = 0; i < 3; i++)
         if (base + i < rx0.size())
            check($sformatf("t3 byte%0d", i), 32'(rx0[base+i]), 32'(exp[i]));
      check("t3 done count", 32'(done0_cnt - d0), 32'd1);

      check("tx_dv never while busy", 32'(viol_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
